flow_accumulator_ci: RTL
========================

FLOW_ACCUMULATOR_CI -- requirements
Module: flowAccumulatorCI

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd0, the ciN value this block responds to.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  custom-instruction start strobe from the CPU.
REQ-005 SHALL have port valueA  input  32  packed flow word: 8 pixels x {up,down,left,right}; pixel i bits [4i+3:4i] = {up,down,left,right}.
REQ-006 SHALL have port valueB  input  32  command: [1:0] op (00 accumulate, 01 read net vector, 10 read {up,down}, 11 read {left,right}); [2] clear-after-read; [31:3] ignored.
REQ-007 SHALL have port ciN  input  8  custom-instruction selector.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result  output  32  return value, valid only while done=1.

Function
REQ-010 SHALL accept a command only when start=1, ciN==customInstructionId and state==IDLE; all other start pulses SHALL be ignored with no state change.
REQ-011 SHALL hold four 16-bit unsigned counters cntUp, cntDown, cntLeft, cntRight.
REQ-012 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-013 On accepted op 00 in cycle T: SHALL latch valueA and go IDLE->ACCUM; cycles T+1..T+4 SHALL each process 2 pixels (pairs 0-1, 2-3, 4-5, 6-7) via a 3-bit beat counter.
REQ-014 Each ACCUM beat SHALL add the per-direction flag count of its pixel pair (0..2) to each counter and add the pair's total set flags to an 6-bit word-flag tally.
REQ-015 Counters SHALL saturate at 16'hFFFF; no wrap-around.
REQ-016 After beat 4, FSM SHALL enter DONE; done=1 in cycle T+5 with result = {26'd0, word-flag tally (0..32)}; then return to IDLE.
REQ-017 On accepted read op (01/10/11) in cycle T: FSM SHALL go IDLE->DONE; done=1 in cycle T+1 with result sampled from counter values at end of cycle T.
REQ-018 Op 01 result SHALL be {dy, dx}: dx = cntRight-cntLeft, dy = cntDown-cntUp, each computed as 17-bit signed, saturated to 16-bit signed range [-32768, 32767].
REQ-019 Op 10 result SHALL be {cntUp, cntDown}; op 11 SHALL be {cntLeft, cntRight}.
REQ-020 For a read with valueB[2]=1, all four counters SHALL be zero from cycle T+2 on; result in T+1 SHALL reflect pre-clear values.
REQ-021 valueB[2] with op 00 SHALL be ignored.
REQ-022 result SHALL be 32'd0 whenever done=0.
REQ-023 done SHALL never be high for more than one consecutive cycle per accepted command.
REQ-024 valueA changes after acceptance SHALL not affect the in-progress accumulation.

Reset
REQ-025 resetn=0 SHALL asynchronously force state=IDLE, beat counter=0, tally=0, all counters=0, done=0, result=0.
REQ-026 Reset asserted mid-ACCUM SHALL abort the command; no done pulse SHALL follow for it after release.
REQ-027 First command SHALL be accepted in the first clock edge with resetn=1 and start=1.

Verification
REQ-028 Accumulate valueA=0x11111111 at T -> done=1 only in T+5, result=0x00000008; read op 01 -> 0x00000008.
REQ-029 From reset, accumulate 0x22222222 twice then 0x88888888 once -> read op 01 returns 0xFFF8FFF0; op 11 returns 0x00100000; op 10 returns 0x00080000.
REQ-030 Accumulate 0xFFFFFFFF -> result=0x00000020; read op 10 with valueB=0x6 -> 0x00080008, subsequent op 10 -> 0x00000000.
REQ-031 8192 accumulations of 0x11111111 -> op 11 returns 0x0000FFFF; op 01 returns 0x00007FFF (dx saturated).
REQ-032 start with ciN!=customInstructionId, and start during ACCUM -> no done, counters unchanged; resetn pulsed at T+2 of an accumulate -> done stays 0, all counters read 0.

Source files
------------

// File: rtl/flow_accumulator_ci.sv
// flow_accumulator_ci
//   CPU custom-instruction block that accumulates optical-flow direction
//   flags into four saturating 16-bit counters and returns net or raw
//   vectors on request.
//
//   Ports
//     clock   : rising-edge clock for all state
//     resetn  : asynchronous active-low reset
//     start   : custom-instruction start strobe
//     valueA  : packed flow word, pixel i nibble [4i+3:4i] = {up,down,left,right}
//     valueB  : command, [1:0] op, [2] clear-after-read, [31:3] unused
//     ciN     : custom-instruction selector, matched against customInstructionId
//     done    : one-cycle completion pulse
//     result  : return value, zero whenever done is low
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a start strobe addressed to this block
//   ACCUM | four beats, two pixels per beat, from the latched flow word
//   DONE  | done/result presented for one cycle, then back to IDLE
module flow_accumulator_ci #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state;
  logic [31:0] word;
  logic [2:0]  beat;
  logic [5:0]  tally;
  logic [15:0] cnt_up;
  logic [15:0] cnt_down;
  logic [15:0] cnt_left;
  logic [15:0] cnt_right;

  logic        accept;
  logic [7:0]  pair;
  logic [1:0]  inc_up;
  logic [1:0]  inc_down;
  logic [1:0]  inc_left;
  logic [1:0]  inc_right;
  logic [3:0]  pair_total;
  logic [5:0]  tally_next;
  logic [31:0] read_val;

  // Upper command bits carry no meaning for this block.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^valueB[31:3];

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // 17-bit difference of two unsigned counters, clamped to the signed
  // 16-bit range. Bits [16:15] disagree exactly when the value does not
  // fit in 16 signed bits.
  function automatic logic [15:0] sat_diff(input logic [15:0] p, input logic [15:0] m);
    logic [16:0] d;
    d = {1'b0, p} - {1'b0, m};
    if (d[16:15] == 2'b01)      return 16'h7FFF;
    else if (d[16:15] == 2'b10) return 16'h8000;
    else                        return d[15:0];
  endfunction

  assign accept = start && (ciN == customInstructionId) && (state == IDLE);

  always_comb begin
    pair = 8'd0;
    case (beat)
      3'd0:    pair = word[7:0];
      3'd1:    pair = word[15:8];
      3'd2:    pair = word[23:16];
      default: pair = word[31:24];
    endcase
    inc_up     = {1'b0, pair[7]} + {1'b0, pair[3]};
    inc_down   = {1'b0, pair[6]} + {1'b0, pair[2]};
    inc_left   = {1'b0, pair[5]} + {1'b0, pair[1]};
    inc_right  = {1'b0, pair[4]} + {1'b0, pair[0]};
    pair_total = {2'b00, inc_up} + {2'b00, inc_down}
               + {2'b00, inc_left} + {2'b00, inc_right};
    tally_next = tally + {2'b00, pair_total};
  end

  always_comb begin
    read_val = 32'd0;
    case (valueB[1:0])
      2'b01:   read_val = {sat_diff(cnt_down, cnt_up), sat_diff(cnt_right, cnt_left)};
      2'b10:   read_val = {cnt_up, cnt_down};
      2'b11:   read_val = {cnt_left, cnt_right};
      default: read_val = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      word      <= 32'd0;
      beat      <= 3'd0;
      tally     <= 6'd0;
      cnt_up    <= 16'd0;
      cnt_down  <= 16'd0;
      cnt_left  <= 16'd0;
      cnt_right <= 16'd0;
      done      <= 1'b0;
      result    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          result <= 32'd0;
          if (accept) begin
            if (valueB[1:0] == 2'b00) begin
              word  <= valueA;
              beat  <= 3'd0;
              tally <= 6'd0;
              state <= ACCUM;
            end else begin
              // Result is taken from the pre-clear counter values.
              result <= read_val;
              done   <= 1'b1;
              state  <= DONE;
              if (valueB[2]) begin
                cnt_up    <= 16'd0;
                cnt_down  <= 16'd0;
                cnt_left  <= 16'd0;
                cnt_right <= 16'd0;
              end
            end
          end
        end
        ACCUM: begin
          cnt_up    <= sat_add(cnt_up, inc_up);
          cnt_down  <= sat_add(cnt_down, inc_down);
          cnt_left  <= sat_add(cnt_left, inc_left);
          cnt_right <= sat_add(cnt_right, inc_right);
          tally     <= tally_next;
          if (beat == 3'd3) begin
            beat   <= 3'd0;
            state  <= DONE;
            done   <= 1'b1;
            result <= {26'd0, tally_next};
          end else begin
            beat <= beat + 3'd1;
          end
        end
        DONE: begin
          done   <= 1'b0;
          result <= 32'd0;
          state  <= IDLE;
        end
        default: begin
          done   <= 1'b0;
          result <= 32'd0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
